gshare_branch_predictor: RTL

Parametrised next-generation branch prediction unit for the IF stage, replacing the per-PC 2-bit counter table. Direction is predicted by a gshare pattern history table (PC XOR global history) with configurable-width saturating counters; targets come from a separate tagged BTB. Speculative global history is kept with mispredict repair from the EX-stage update port. After reset, a hardware init sweep clears both tables.

---
 rtl/gshare_branch_predictor.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor (PC xor global history into saturating counters)
// with a separate tagged BTB, speculative GHR, mispredict repair and init sweep.
module gshare_branch_predictor #(
  parameter int PC_WIDTH    = 32,
  parameter int PHT_ENTRIES = 1024,
  parameter int BTB_ENTRIES = 256,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 10,
  parameter int TAG_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic                pred_valid,
  input  logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_resp_valid,
  output logic                pred_taken,
  output logic                pred_hit,
  output logic [PC_WIDTH-1:0] pred_target,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                upd_mispredict,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
);

  localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int SWEEP_LEN = (PHT_ENTRIES > BTB_ENTRIES) ? PHT_ENTRIES : BTB_ENTRIES;
  localparam int SWEEP_W   = $clog2(SWEEP_LEN);
  localparam int TAG_LO    = BTB_IDX_W + 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX >> 1;

  typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t state, state_next;
  logic   sweeping;
  logic [SWEEP_W-1:0] sweep_idx;
  logic   sweep_last;
  logic   pht_sweep_en, btb_sweep_en;

  logic [CTR_BITS-1:0] pht        [PHT_ENTRIES];
  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0] btb_target [BTB_ENTRIES];

  logic [GHR_BITS-1:0]  ghr;
  logic [PHT_IDX_W-1:0] pred_pht_idx, upd_pht_idx;
  logic [BTB_IDX_W-1:0] pred_btb_idx, upd_btb_idx;
  logic [TAG_BITS-1:0]  pred_tag, upd_tag;
  logic [CTR_BITS-1:0]  pred_ctr, upd_ctr, upd_ctr_next;
  logic                 pred_hit_c, pred_dir;
  logic                 accept_pred, accept_upd;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc, upd_pc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (sweep_last) state_next = S_READY;
      S_READY: state_next = S_READY;
      default: state_next = S_INIT;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    sweeping = 1'b0;
    case (state)
      S_INIT:  sweeping = 1'b1;
      S_READY: ready    = 1'b1;
      default: sweeping = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           sweep_idx <= '0;
    else if (sweeping) sweep_idx <= sweep_idx + SWEEP_W'(1);
  end

  assign sweep_last = (sweep_idx == SWEEP_W'(SWEEP_LEN - 1));

  // The smaller table finishes early and simply stops being written.
  if (PHT_ENTRIES == SWEEP_LEN) begin : g_pht_full
    assign pht_sweep_en = 1'b1;
  end else begin : g_pht_part
    assign pht_sweep_en = (sweep_idx < SWEEP_W'(PHT_ENTRIES));
  end

  if (BTB_ENTRIES == SWEEP_LEN) begin : g_btb_full
    assign btb_sweep_en = 1'b1;
  end else begin : g_btb_part
    assign btb_sweep_en = (sweep_idx < SWEEP_W'(BTB_ENTRIES));
  end

  assign accept_pred = ready & pred_valid;
  assign accept_upd  = ready & upd_valid;

  assign pred_pht_idx = pred_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign pred_btb_idx = pred_pc[BTB_IDX_W+1:2];
  assign pred_tag     = pred_pc[TAG_LO +: TAG_BITS];
  assign pred_ctr     = pht[pred_pht_idx];
  assign pred_hit_c   = btb_valid[pred_btb_idx] && (btb_tag[pred_btb_idx] == pred_tag);
  assign pred_dir     = pred_hit_c & pred_ctr[CTR_BITS-1];

  assign upd_pht_idx = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
  assign upd_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign upd_tag     = upd_pc[TAG_LO +: TAG_BITS];
  assign upd_ctr     = pht[upd_pht_idx];

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_BITS'(1);
    end
  end

  // Table storage has no reset; the init sweep is what clears it.
  always_ff @(posedge clk) begin
    if (sweeping) begin
      if (pht_sweep_en) pht[sweep_idx[PHT_IDX_W-1:0]] <= CTR_INIT;
      if (btb_sweep_en) btb_valid[sweep_idx[BTB_IDX_W-1:0]] <= 1'b0;
    end else if (upd_valid) begin
      pht[upd_pht_idx] <= upd_ctr_next;
      if (upd_taken) begin
        btb_valid[upd_btb_idx]  <= 1'b1;
        btb_tag[upd_btb_idx]    <= upd_tag;
        btb_target[upd_btb_idx] <= upd_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_resp_valid  <= 1'b0;
      pred_taken       <= 1'b0;
      pred_hit         <= 1'b0;
      pred_target      <= '0;
      pred_ghr         <= '0;
      ghr              <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      pred_resp_valid <= accept_pred;
      if (accept_pred) begin
        pred_taken  <= pred_dir;
        pred_hit    <= pred_hit_c;
        pred_target <= pred_hit_c ? btb_target[pred_btb_idx] : '0;
        pred_ghr    <= ghr;
      end
      // Repair from EX overrides the speculative shift of the same cycle.
      if (accept_upd && upd_mispredict)
        ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
      else if (accept_pred)
        ghr <= {ghr[GHR_BITS-2:0], pred_dir};
      if (accept_upd) begin
        if (stat_updates != '1) stat_updates <= stat_updates + 32'd1;
        if (upd_mispredict && (stat_mispredicts != '1))
          stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule
